// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// The pipeline stage carries the full byte address so that range errors can be detected at the final stage.
package inst_mem_pkg;

  // Legal range of the Latency parameter.
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  // Word returned on misaligned or out-of-range fetches.
  localparam logic [31:0] ERR_DATA = 32'h0;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } stage_t;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction store: one synchronous write port and one registered read port.
// A write and a read of the same word in one cycle return the old contents.
module inst_mem_array #(
  parameter  int DataWidth = 32,
  parameter  int Depth     = 1024,
  localparam int AddrW     = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AddrW-1:0]     wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [AddrW-1:0]     rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem [Depth];
  logic [DataWidth-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Fetch responder: Latency-deep request pipeline in front of the instruction store,
// with hold (freeze), flush (drop in-flight) and a wrapping response counter.
module inst_mem_responder
  import inst_mem_pkg::*;
#(
  parameter  int DataWidth = 32,
  parameter  int Depth     = 1024,
  parameter  int Latency   = 2,
  localparam int AddrW     = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 request_i,
  input  logic [31:0]          instAddr_i,
  output logic                 accept_o,
  input  logic                 hold_i,
  input  logic                 flush_i,
  output logic                 dataOk_o,
  output logic [DataWidth-1:0] inst_o,
  output logic                 addrErr_o,
  input  logic                 loadEn_i,
  input  logic [AddrW-1:0]     loadAddr_i,
  input  logic [DataWidth-1:0] loadData_i,
  output logic [31:0]          respCount_o
);

  localparam logic [31:0] BYTE_LIMIT = 32'(Depth * 4);

  stage_t               stage_q [Latency];
  stage_t               stage_d [Latency];
  logic                 data_ok_q, data_ok_d;
  logic                 addr_err_q, addr_err_d;
  logic                 zero_q, zero_d;
  logic [31:0]          resp_count_q, resp_count_d;

  stage_t               final_stage;
  logic                 final_err;
  logic                 fire;
  logic                 rd_en;
  logic [DataWidth-1:0] rd_data;

  assign accept_o    = ~reset & ~hold_i & ~flush_i;
  assign final_stage = stage_q[Latency-1];
  assign final_err   = (final_stage.addr[1:0] != 2'b00) | (final_stage.addr >= BYTE_LIMIT);
  assign fire        = ~hold_i & ~flush_i & final_stage.valid;
  assign rd_en       = fire & ~final_err;

  always_comb begin
    for (int i = 0; i < Latency; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (flush_i) begin
      for (int i = 0; i < Latency; i++) begin
        stage_d[i].valid = 1'b0;
      end
    end else if (!hold_i) begin
      stage_d[0].valid = request_i & accept_o;
      stage_d[0].addr  = instAddr_i;
      for (int i = 1; i < Latency; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // zero_q forces inst_o to ERR_DATA after reset and after an error response,
  // since the registered read data itself is never reset.
  always_comb begin
    data_ok_d    = fire;
    addr_err_d   = fire ? final_err : addr_err_q;
    zero_d       = fire ? final_err : zero_q;
    resp_count_d = resp_count_q + {31'b0, data_ok_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Latency; i++) begin
        stage_q[i] <= '0;
      end
      data_ok_q    <= 1'b0;
      addr_err_q   <= 1'b0;
      zero_q       <= 1'b1;
      resp_count_q <= 32'd0;
    end else begin
      for (int i = 0; i < Latency; i++) begin
        stage_q[i] <= stage_d[i];
      end
      data_ok_q    <= data_ok_d;
      addr_err_q   <= addr_err_d;
      zero_q       <= zero_d;
      resp_count_q <= resp_count_d;
    end
  end

  inst_mem_array #(
    .DataWidth(DataWidth),
    .Depth    (Depth)
  ) u_array (
    .clk    (clk),
    .wr_en  (loadEn_i),
    .wr_addr(loadAddr_i),
    .wr_data(loadData_i),
    .rd_en  (rd_en),
    .rd_addr(final_stage.addr[AddrW+1:2]),
    .rd_data(rd_data)
  );

  assign dataOk_o    = data_ok_q;
  assign inst_o      = zero_q ? DataWidth'(ERR_DATA) : rd_data;
  assign addrErr_o   = addr_err_q;
  assign respCount_o = resp_count_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Randomized and directed bench for inst_mem_responder; a queue of pending fetches with
// remaining-delay counters serves as the reference model.
module tb_inst_mem_responder;

  localparam int DW  = 32;
  localparam int DEP = 1024;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset, request_i, hold_i, flush_i, loadEn_i;
  logic [31:0] instAddr_i, loadData_i;
  logic [9:0]  loadAddr_i;
  logic        accept_o, dataOk_o, addrErr_o;
  logic [31:0] inst_o, respCount_o;

  inst_mem_responder #(.DataWidth(DW), .Depth(DEP), .Latency(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .request_i  (request_i),
    .instAddr_i (instAddr_i),
    .accept_o   (accept_o),
    .hold_i     (hold_i),
    .flush_i    (flush_i),
    .dataOk_o   (dataOk_o),
    .inst_o     (inst_o),
    .addrErr_o  (addrErr_o),
    .loadEn_i   (loadEn_i),
    .loadAddr_i (loadAddr_i),
    .loadData_i (loadData_i),
    .respCount_o(respCount_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [31:0] addr;
    int          rem;
  } pend_t;

  pend_t       pend [$];
  logic [31:0] mem_m [DEP];
  logic        e_ok, e_err;
  logic [31:0] e_inst, e_cnt;

  task automatic model_edge(input logic rst, req, hld, fl, le, input logic [31:0] addr,
                            input logic [9:0] la, input logic [31:0] ld);
    pend_t p;
    logic  err;
    if (rst) begin
      pend.delete();
      e_ok = 1'b0; e_err = 1'b0; e_inst = 32'h0; e_cnt = 32'h0;
    end else begin
      e_cnt = e_cnt + {31'b0, e_ok};
      e_ok  = 1'b0;
      if (fl) begin
        pend.delete();
      end else if (!hld) begin
        foreach (pend[i]) pend[i].rem--;
        if (pend.size() > 0 && pend[0].rem == 0) begin
          p      = pend.pop_front();
          err    = (p.addr[1:0] != 2'b00) || (p.addr >= DEP * 4);
          e_ok   = 1'b1;
          e_err  = err;
          e_inst = err ? 32'h0 : mem_m[p.addr[11:2]];
        end
        if (req) pend.push_back('{addr, LAT});
      end
    end
    if (le) mem_m[la] = ld;
  endtask

  task automatic step(input logic rst, req, input logic [31:0] addr, input logic hld, fl,
                      input logic le = 1'b0, input logic [9:0] la = '0, input logic [31:0] ld = '0);
    @(negedge clk);
    reset = rst; request_i = req; instAddr_i = addr; hold_i = hld; flush_i = fl;
    loadEn_i = le; loadAddr_i = la; loadData_i = ld;
    #1;
    check("accept", {31'b0, accept_o}, {31'b0, !rst && !hld && !fl});
    @(posedge clk);
    model_edge(rst, req && !rst && !hld && !fl, hld, fl, le, addr, la, ld);
    #1;
    $display("step rst=%0b req=%0b addr=%h hold=%0b flush=%0b | ok=%0b inst=%h err=%0b cnt=%0d",
             rst, req, addr, hld, fl, dataOk_o, inst_o, addrErr_o, respCount_o);
    check("dataOk", {31'b0, dataOk_o}, {31'b0, e_ok});
    check("inst", inst_o, e_inst);
    check("addrErr", {31'b0, addrErr_o}, {31'b0, e_err});
    check("respCount", respCount_o, e_cnt);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 63)) << 2;
    else if (r == 7) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 8) return 32'(DEP * 4) + (32'($urandom_range(0, 1000)) << 2);
    else             return 32'hFFFF_FFFC;
  endfunction

  initial begin
    reset = 1'b1; request_i = 1'b0; instAddr_i = '0; hold_i = 1'b0; flush_i = 1'b0;
    loadEn_i = 1'b0; loadAddr_i = '0; loadData_i = '0;
    e_ok = 1'b0; e_err = 1'b0; e_inst = '0; e_cnt = '0;

    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Preload the words the stimulus can reach
    for (int w = 0; w < 64; w++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 10'(w), $urandom);
    for (int w = 0; w < 4; w++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 10'(w), 32'(w + 1));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 10'd4, 32'hDEADBEEF);

    // Single fetch: pulse two cycles after acceptance
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t1_early", {31'b0, dataOk_o}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t1_ok", {31'b0, dataOk_o}, 32'd1);
    check("t1_inst", inst_o, 32'hDEADBEEF);
    check("t1_err", {31'b0, addrErr_o}, 32'd0);
    idle(2);

    // Back-to-back, then error fetches
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'(k * 4), 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 32'h2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'(DEP * 4), 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t3_err_a", {31'b0, addrErr_o}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t3_err_b", {31'b0, addrErr_o}, 32'd1);
    check("t3_zero", inst_o, 32'h0);
    idle(2);

    // Hold for two cycles after the request
    step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t4_wait", {31'b0, dataOk_o}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t4_ok", {31'b0, dataOk_o}, 32'd1);
    idle(2);

    // Flush drops the in-flight request; the following one returns mem[2]
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h4, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t5_none", {31'b0, dataOk_o}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t5_inst", inst_o, 32'd3);
    idle(2);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic le;
      le = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), rand_addr(),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
           le, 10'($urandom_range(0, 63)), $urandom);
    end

    // Reset with requests in flight
    step(1'b0, 1'b1, 32'h4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hC, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(4);
    check("t6_cnt", respCount_o, 32'd0);
    check("t6_inst", inst_o, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
# inst_mem_responder

Instruction-memory responder for the fetch request/dataOk protocol. Accepts fetch requests with a byte address from a fetch way, looks the word up in an internal word-addressed array, and returns it with a one-cycle dataOk pulse after a fixed, parameterised latency. It sits between the fetch units and the instruction store, and provides a preload port, a wait-state hold input, and a flush for taken jumps.

## Interface
- DataWidth, 32: instruction word width.
- Depth, 1024: number of words in the array; byte range is 0 .. Depth*4-1.
- Latency, 2: cycles from request acceptance to dataOk; legal range 1..4.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- request_i  input  1  fetch request valid.
- instAddr_i  input  32  fetch byte address.
- accept_o  output  1  combinational; request accepted this cycle when request_i && accept_o.
- hold_i  input  1  wait state; freezes the pipeline.
- flush_i  input  1  discards all in-flight requests (jump).
- dataOk_o  output  1  one-cycle pulse per returned word.
- inst_o  output  DataWidth  returned word; holds its value between pulses.
- addrErr_o  output  1  qualifies dataOk_o; the request was misaligned or out of range.
- loadEn_i  input  1  preload write enable.
- loadAddr_i  input  log2(Depth)  preload word index.
- loadData_i  input  DataWidth  preload data.
- respCount_o  output  32  count of dataOk pulses since reset; wraps.

## Operation
- accept_o = ~reset & ~hold_i & ~flush_i.
- An accepted request enters stage 0 of a Latency-deep valid/address shift pipeline. Requests stay in order. There is no downstream backpressure: every surviving request produces exactly one dataOk_o pulse.
- Final stage:
  - addrErr = (addr[1:0] != 0) | (addr >= Depth*4).
  - If addrErr is clear, inst_o <= mem[addr[log2(Depth)+1:2]]; if set, inst_o <= 0 and addrErr_o <= 1.
- hold_i high:
  - All pipeline stages keep their contents.
  - dataOk_o = 0 on the following cycle.
  - No new request is accepted.
  - The pulse that was due resumes after hold drops.
- flush_i high: all pipeline valid bits clear at that edge; dataOk_o = 0 next cycle; inst_o unchanged.
- Priority: reset > flush_i > hold_i > normal.
- Preload: when loadEn_i is high, mem[loadAddr_i] <= loadData_i at the edge. It is independent of hold and flush. A read of the same word in the same cycle returns the old contents.
- respCount_o increments on every cycle where dataOk_o is high, including error responses.
- Reset values: dataOk_o 0, inst_o 0, addrErr_o 0, respCount_o 0, all pipeline valids 0. Array contents are not reset.
- Reset asserted mid-operation: all in-flight requests are dropped with no pulse.

## Timing
- Request accepted at edge N with no hold: dataOk_o high during cycle N+Latency, with inst_o and addrErr_o valid in that same cycle.
- Back-to-back requests: one pulse per cycle, throughput 1 word/cycle.
- Each hold cycle adds exactly one cycle to every in-flight request.
- Flush at edge F kills requests accepted at edges ≤ F. A request at edge F+1 responds at F+1+Latency.
- dataOk_o, inst_o, addrErr_o and respCount_o are registered. accept_o is the only combinational output.

## Structure
- Shared package inst_mem_pkg:
  - LATENCY_MIN = 1, LATENCY_MAX = 4.
  - ERR_DATA = 32'h0.
  - Pipeline stage struct {valid, addr}.
- Sub-module inst_mem_array: a Depth x DataWidth array with one synchronous write port and one read port. The read port is consumed at the final stage.
- Top level: pipeline shift registers, hold/flush control, error detection, response counter.

## Test plan
- Latency=2. Preload mem[4] = 32'hDEADBEEF. Request 0x10 at edge 0 -> dataOk_o=1 at cycle 2, inst_o=32'hDEADBEEF, addrErr_o=0, respCount_o=1 at cycle 3.
- Four back-to-back requests to 0x0, 0x4, 0x8, 0xC with words 1..4 -> four consecutive pulses with inst_o 1, 2, 3, 4 in order.
- Request 0x2 (misaligned), then request Depth*4 (out of range) -> two pulses, each with inst_o=0 and addrErr_o=1; respCount_o advances by 2.
- Request at edge 0, hold_i high for cycles 1-2 -> dataOk_o first high at cycle 4; accept_o=0 during the hold.
- Requests at edges 0 and 1, flush_i at edge 1, new request 0x8 at edge 2 -> exactly one pulse, at cycle 4, carrying mem[2].
- Requests in flight, reset high for one cycle -> no dataOk_o pulse afterwards; respCount_o=0 and inst_o=0.
